// File: rtl/univ_shift_reg.sv
// ============================================================================
// univ_shift_reg : WIDTH-bit universal shift/rotate/load register with a
//                  saturating shift counter and a one-cycle DONE pulse.
// Revision 1.0
// ============================================================================
`default_nettype none

module univ_shift_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [2:0]                 mode_i,
  input  logic                       sin_r_i,
  input  logic                       sin_l_i,
  input  logic [WIDTH-1:0]           d_i,
  output logic [WIDTH-1:0]           q_o,
  output logic                       sout_l_o,
  output logic                       sout_r_o,
  output logic [$clog2(WIDTH+1)-1:0] cnt_o,
  output logic                       done_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_op;

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_op = 1'b0;
    if (en_i) begin
      case (mode_i)
        MODE_HOLD: q_d = q_q;
        MODE_SHL:  begin q_d = {q_q[WIDTH-2:0], sin_r_i};   shift_op = 1'b1; end
        MODE_SHR:  begin q_d = {sin_l_i, q_q[WIDTH-1:1]};   shift_op = 1'b1; end
        MODE_ROL:  begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; shift_op = 1'b1; end
        MODE_ROR:  begin q_d = {q_q[0], q_q[WIDTH-1:1]};    shift_op = 1'b1; end
        MODE_LOAD: begin q_d = d_i;      cnt_d = '0; end
        MODE_ASR:  begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; shift_op = 1'b1; end
        MODE_CLR:  begin q_d = '0;       cnt_d = '0; end
        default:   q_d = q_q;
      endcase
      // Counter saturates at WIDTH; DONE fires only on the transition into it.
      if (shift_op && (cnt_q != CNT_FULL)) begin
        cnt_d  = cnt_q + 1'b1;
        done_d = (cnt_q == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q_o      = q_q;
  assign cnt_o    = cnt_q;
  assign done_o   = done_q;
  assign sout_l_o = q_q[WIDTH-1];
  assign sout_r_o = q_q[0];

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// tb_univ_shift_reg : directed and randomized checks of univ_shift_reg
//                     (WIDTH=8, RESET_VAL=8'hA5) against an arithmetic model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       en_i = 1'b0;
  logic [2:0] mode_i = 3'd0;
  logic       sin_r_i = 1'b0;
  logic       sin_l_i = 1'b0;
  logic [7:0] d_i = 8'h00;
  logic [7:0] q_o;
  logic       sout_l_o, sout_r_o;
  logic [3:0] cnt_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;

  // Reference state: value as an integer 0..255, shift count, pulse flag
  int   m_q;
  int   m_cnt;
  logic m_done;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i),
    .sin_r_i(sin_r_i), .sin_l_i(sin_l_i), .d_i(d_i), .q_o(q_o),
    .sout_l_o(sout_l_o), .sout_r_o(sout_r_o), .cnt_o(cnt_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one operation across one rising edge and advance the model.
  task automatic drive(input logic en, input int mode, input int sr, input int sl, input int d);
    bit shifting;
    en_i = en; mode_i = 3'(mode); sin_r_i = sr[0]; sin_l_i = sl[0]; d_i = 8'(d);
    @(posedge clk_i);
    shifting = 1'b0;
    m_done = 1'b0;
    if (en) begin
      case (mode)
        1: begin m_q = (m_q * 2) % 256 + sr;               shifting = 1'b1; end
        2: begin m_q = m_q / 2 + sl * 128;                 shifting = 1'b1; end
        3: begin m_q = (m_q * 2) % 256 + m_q / 128;        shifting = 1'b1; end
        4: begin m_q = m_q / 2 + (m_q % 2) * 128;          shifting = 1'b1; end
        5: begin m_q = d;   m_cnt = 0; end
        6: begin m_q = m_q / 2 + ((m_q >= 128) ? 128 : 0); shifting = 1'b1; end
        7: begin m_q = 0;   m_cnt = 0; end
        default: ;
      endcase
      if (shifting && m_cnt < 8) begin
        m_cnt = m_cnt + 1;
        m_done = (m_cnt == 8);
      end
    end
    #1;
  endtask

  task automatic model_reset();
    m_q = 8'hA5; m_cnt = 0; m_done = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({q_o, cnt_o, done_o} !== {8'hA5, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async q=%h cnt=%0d done=%b required q=a5 cnt=0 done=0", q_o, cnt_o, done_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255));
      checks++;
      if ({q_o, cnt_o, done_o} !== {8'hA5, 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL reset_en0_hold[%0d] q=%h cnt=%0d done=%b required q=a5 cnt=0 done=0", i, q_o, cnt_o, done_o);
      end
    end
  endtask

  task automatic test_rotate();
    logic [7:0] exp [4] = '{8'h03, 8'h06, 8'h03, 8'h81};
    drive(1'b1, 5, 0, 0, 8'h81);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i < 2) ? 3 : 4, 0, 0, 0);
      checks++;
      if (q_o !== exp[i] || q_o !== 8'(m_q)) begin
        errors++;
        $display("FAIL rotate[%0d] q=%h required %h", i, q_o, exp[i]);
      end
    end
    checks++;
    if (cnt_o !== 4'd4 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL rotate_cnt cnt=%0d done=%b required cnt=4 done=0", cnt_o, done_o);
    end
  endtask

  task automatic test_shift_left_done();
    logic [7:0] sin_seq = 8'b1011_0010;  // MSB is the first bit shifted in
    logic [7:0] sout_seq = 8'b1011_0100;
    drive(1'b1, 5, 0, 0, 8'hB4);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sout_l_o !== sout_seq[7-i]) begin
        errors++;
        $display("FAIL shl_sout_l[%0d] sout_l=%b required %b", i, sout_l_o, sout_seq[7-i]);
      end
      drive(1'b1, 1, int'(sin_seq[7-i]), 0, 0);
      checks++;
      if ({q_o, cnt_o, done_o, sout_l_o, sout_r_o} !==
          {8'(m_q), 4'(m_cnt), m_done, 1'(m_q / 128), 1'(m_q % 2)} || done_o !== (i == 7)) begin
        errors++;
        $display("FAIL shl_step[%0d] q=%h cnt=%0d done=%b required q=%h cnt=%0d done=%b",
                 i, q_o, cnt_o, done_o, 8'(m_q), m_cnt, m_done);
      end
    end
    checks++;
    if (q_o !== 8'hB2) begin
      errors++;
      $display("FAIL shl_final q=%h required b2", q_o);
    end
    drive(1'b1, 1, 1, 0, 0);
    checks++;
    if (cnt_o !== 4'd8 || done_o !== 1'b0 || q_o !== 8'h65) begin
      errors++;
      $display("FAIL shl_saturate q=%h cnt=%0d done=%b required q=65 cnt=8 done=0", q_o, cnt_o, done_o);
    end
  endtask

  task automatic test_arith_shift();
    logic [7:0] exp [3] = '{8'hC8, 8'hE4, 8'h72};
    drive(1'b1, 5, 0, 0, 8'h90);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i < 2) ? 6 : 2, 0, 0, 0);
      checks++;
      if (q_o !== exp[i] || q_o !== 8'(m_q) || cnt_o !== 4'(i + 1)) begin
        errors++;
        $display("FAIL shift_right[%0d] q=%h cnt=%0d required q=%h cnt=%0d", i, q_o, cnt_o, exp[i], i + 1);
      end
    end
  endtask

  task automatic test_load_clear_wins();
    for (int r = 0; r < 2; r++) begin
      drive(1'b1, 5, 0, 0, $urandom_range(0, 255));
      for (int i = 0; i < 7; i++)
        drive(1'b1, 1, $urandom_range(0, 1), 0, 0);
      checks++;
      if (cnt_o !== 4'd7) begin
        errors++;
        $display("FAIL pre_override[%0d] cnt=%0d required 7", r, cnt_o);
      end
      drive(1'b1, (r == 0) ? 5 : 7, 1, 1, 8'h3C);
      checks++;
      if ({q_o, cnt_o, done_o} !== {((r == 0) ? 8'h3C : 8'h00), 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL override[%0d] q=%h cnt=%0d done=%b required q=%h cnt=0 done=0",
                 r, q_o, cnt_o, done_o, (r == 0) ? 8'h3C : 8'h00);
      end
      drive(1'b1, 0, 0, 0, 0);
      checks++;
      if (done_o !== 1'b0 || cnt_o !== 4'd0) begin
        errors++;
        $display("FAIL override_hold[%0d] cnt=%0d done=%b required cnt=0 done=0", r, cnt_o, done_o);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    drive(1'b1, 5, 0, 0, 8'h5A);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 2, 1, 1, 0);
    checks++;
    if (cnt_o !== 4'd5) begin
      errors++;
      $display("FAIL mid_pre cnt=%0d required 5", cnt_o);
    end
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({q_o, cnt_o, done_o} !== {8'hA5, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset q=%h cnt=%0d done=%b required q=a5 cnt=0 done=0", q_o, cnt_o, done_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive(1'b1, 3, 0, 0, 0);
    checks++;
    if (cnt_o !== 4'd1 || q_o !== 8'h4B) begin
      errors++;
      $display("FAIL mid_resume q=%h cnt=%0d required q=4b cnt=1", q_o, cnt_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 255));
      checks++;
      if ({q_o, cnt_o, done_o, sout_l_o, sout_r_o} !==
          {8'(m_q), 4'(m_cnt), m_done, 1'(m_q / 128), 1'(m_q % 2)}) begin
        errors++;
        $display("FAIL random[%0d] q=%h cnt=%0d done=%b sl=%b sr=%b required q=%h cnt=%0d done=%b",
                 i, q_o, cnt_o, done_o, sout_l_o, sout_r_o, 8'(m_q), m_cnt, m_done);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotate();
    test_shift_left_done();
    test_arith_shift();
    test_load_clear_wins();
    test_reset_mid_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
